// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the
// MMIO block. The output is first-word-fall-through: the head byte is always
// presented on out_data while out_valid is high.
//
// Pointers are AW+1 bits wide. The extra MSB tells a full FIFO apart from an
// empty one, so both flags are decoded from the pointers. Occupancy is
// reported as the modular difference of the two pointers.
//
// Optional feature macro: UART_RX_FIFO_OVF_CNT_EN
//   When defined, adds a 16-bit saturating count of dropped bytes (ovf_cnt).
//   When undefined, the port and its logic do not exist.

module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
`ifdef UART_RX_FIFO_OVF_CNT_EN
  output logic             overflow,
  output logic [15:0]      ovf_cnt
`else
  output logic             overflow
`endif
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      wptr_q, wptr_d;
  logic             ovf_q, ovf_d;

  logic push;
  logic pop;
  logic push_ok;
  logic drop;

  // Flags come straight from the pointers; the MSB distinguishes full from empty.
  always_comb begin
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty = (wptr_q == rptr_q);
  end

  assign in_ready  = 1'b1;
  assign out_valid = ~empty;
  assign out_data  = mem_q[rptr_q[AW-1:0]];
  assign count     = wptr_q - rptr_q;

  // A pop while empty is ignored. When full, a push still fits if the head
  // leaves in the same cycle.
  always_comb begin
    push    = in_valid;
    pop     = out_ready & ~empty;
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  // Next pointer and sticky overflow state; clr discards any same-cycle push or pop.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    ovf_d  = ovf_q;
    if (clr) begin
      rptr_d = '0;
      wptr_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (pop)     rptr_d = rptr_q + PTR_ONE;
      if (drop)    ovf_d  = 1'b1;
    end
  end

  // Pointer and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage array; contents need no reset because out_valid gates them.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= in_data;
    end
  end

  assign overflow = ovf_q;

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of dropped bytes, cleared together with the sticky flag.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr) begin
      ovf_cnt_d = '0;
    end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run, all compared against a queue-based reference model of the FIFO.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [15:0]      ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a plain byte queue, a sticky flag and a drop counter.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf = 1'b0;
  int               m_drops = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
`ifdef UART_RX_FIFO_OVF_CNT_EN
    .overflow (overflow),
    .ovf_cnt  (ovf_cnt)
`else
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, and return
  // at the following negedge where outputs are sampled.
  task automatic step(input bit r, input bit c, input bit v,
                      input logic [WIDTH-1:0] d, input bit p);
    int  pre_size;
    bit  pop_ok;
    rst = r; clr = c; in_valid = v; in_data = d; out_ready = p;
    @(posedge clk);
    if (r || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_drops = 0;
    end else begin
      pre_size = mq.size();
      pop_ok = p && (pre_size > 0);
      if (pop_ok) void'(mq.pop_front());
      if (v) begin
        if (pre_size < DEPTH || pop_ok) mq.push_back(d);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 8'h00, 0);
    step(1, 1, 1, 8'h77, 1);
    checks++;
    if ({count, full, empty, out_valid, overflow} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got count=%0d full=%b empty=%b out_valid=%b overflow=%b, expected 0/0/1/0/0",
               count, full, empty, out_valid, overflow);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready: got %b expected 1", in_ready);
    end
`ifdef UART_RX_FIFO_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt);
    end
`endif
  endtask

  task automatic test_single();
    step(0, 0, 1, 8'hA5, 0);
    checks++;
    if ({out_valid, out_data, count} !== {1'b1, 8'hA5, 4'd1}) begin
      errors++;
      $display("FAIL single_push: got valid=%b data=%h count=%0d expected 1/a5/1",
               out_valid, out_data, count);
    end
    step(0, 0, 0, 8'h00, 1);
    checks++;
    if ({empty, count} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL single_pop: got empty=%b count=%0d expected 1/0", empty, count);
    end
  endtask

  task automatic test_fill_drain();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, WIDTH'(i), 0);
      checks++;
      if ({full, count} !== {1'b1, 4'd8}) begin
        errors++;
        $display("FAIL fill_%0d: got full=%b count=%0d expected 1/8", rep, full, count);
      end
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
          errors++;
          $display("FAIL drain_order_%0d_%0d: got valid=%b data=%h expected 1/%h",
                   rep, i, out_valid, out_data, WIDTH'(i));
        end
        step(0, 0, 0, 8'h00, 1);
      end
      checks++;
      if ({empty, count} !== {1'b1, 4'd0}) begin
        errors++;
        $display("FAIL drain_empty_%0d: got empty=%b count=%0d expected 1/0", rep, empty, count);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, WIDTH'(i), 0);
    step(0, 0, 1, 8'hFF, 0);
    checks++;
    if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overflow_drop: got count=%0d full=%b overflow=%b expected 8/1/1",
               count, full, overflow);
    end
`ifdef UART_RX_FIFO_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ovf_cnt_one: got %0d expected 1", ovf_cnt);
    end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_data !== WIDTH'(i)) begin
        errors++;
        $display("FAIL overflow_drain_%0d: got %h expected %h", i, out_data, WIDTH'(i));
      end
      step(0, 0, 0, 8'h00, 1);
    end
    checks++;
    if ({empty, overflow} !== {1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overflow_sticky: got empty=%b overflow=%b expected 1/1", empty, overflow);
    end
    step(0, 1, 0, 8'h00, 0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: got %b expected 0", overflow);
    end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, WIDTH'(8'h10 + i), 0);
    step(0, 0, 1, 8'h55, 1);
    checks++;
    if ({count, full, overflow, out_data} !== {4'd8, 1'b1, 1'b0, 8'h11}) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d full=%b overflow=%b head=%h expected 8/1/0/11",
               count, full, overflow, out_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_data !== ((i == DEPTH - 1) ? 8'h55 : WIDTH'(8'h11 + i))) begin
        errors++;
        $display("FAIL full_push_pop_drain_%0d: got %h", i, out_data);
      end
      step(0, 0, 0, 8'h00, 1);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, WIDTH'(8'h20 + i), 0);
    step(0, 0, 1, 8'hEE, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);
    checks++;
    if ({count, overflow} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL flush_pre: got count=%0d overflow=%b expected 5/1", count, overflow);
    end
    step(0, 1, 1, 8'h99, 1);
    checks++;
    if ({count, overflow, empty, out_valid} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL flush_state: got count=%0d overflow=%b empty=%b valid=%b expected 0/0/1/0",
               count, overflow, empty, out_valid);
    end
`ifdef UART_RX_FIFO_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush_ovf_cnt: got %0d expected 0", ovf_cnt);
    end
`endif
    step(0, 0, 1, 8'h3C, 0);
    checks++;
    if ({out_valid, out_data, count} !== {1'b1, 8'h3C, 4'd1}) begin
      errors++;
      $display("FAIL flush_repush: got valid=%b data=%h count=%0d expected 1/3c/1",
               out_valid, out_data, count);
    end
    step(0, 0, 1, 8'h44, 0);
    step(1, 0, 1, 8'h45, 1);
    checks++;
    if ({count, empty} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_burst: got count=%0d empty=%b expected 0/1", count, empty);
    end
  endtask

  task automatic test_random();
    bit r, c, v, p;
    logic [WIDTH-1:0] d;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 99) < 60);
      p = ($urandom_range(0, 99) < 45);
      d = WIDTH'($urandom);
      step(r, c, v, d, p);
      checks++;
      if ({count, full, empty, out_valid, overflow} !==
          {CW'(mq.size()), mq.size() == DEPTH, mq.size() == 0, mq.size() != 0, m_ovf}) begin
        errors++;
        $display("FAIL random_status_%0d: got count=%0d full=%b empty=%b valid=%b ovf=%b expected count=%0d ovf=%b",
                 n, count, full, empty, out_valid, overflow, mq.size(), m_ovf);
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_data !== mq[0]) begin
          errors++;
          $display("FAIL random_head_%0d: got %h expected %h", n, out_data, mq[0]);
        end
      end
`ifdef UART_RX_FIFO_OVF_CNT_EN
      checks++;
      if (ovf_cnt !== 16'(m_drops)) begin
        errors++;
        $display("FAIL random_ovf_cnt_%0d: got %0d expected %0d", n, ovf_cnt, m_drops);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_push_pop_full();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between the UART receiver's data_out handshake and the core's memory-mapped IO block.
- Decouples byte arrival from software polling, so bursts of up to DEPTH bytes survive without loss.
- Reports occupancy and overflow status for the UART control register.
- Output is first-word-fall-through: the head byte is always presented on out_data.

Parameters:
- DEPTH, 8, number of byte entries; must be a power of two, minimum 2.
- WIDTH, 8, data width in bits.
- AW, $clog2(DEPTH), pointer index width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  synchronous flush: empties the FIFO and clears overflow.
- in_data  in  WIDTH  byte from the UART receiver.
- in_valid  in  1  receiver byte valid.
- in_ready  out  1  tied to 1; the FIFO never backpressures the receiver.
- out_data  out  WIDTH  head-of-queue byte; valid only while out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer pop request; asserted for one cycle per MMIO read of RDATA.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky flag: a byte was dropped.

Behaviour:
- Storage: DEPTH x WIDTH register array. Read pointer rptr and write pointer wptr are AW+1 bits each.
  - Full when MSBs differ and low bits are equal.
  - Empty when the pointers are equal.
- Reset (rst=1): rptr=0, wptr=0, overflow=0.
  - Resulting outputs: count=0, empty=1, full=0, out_valid=0.
  - Array contents are don't-care.
  - rst has priority over every other input.
- push = in_valid. pop = out_ready & out_valid. A pop while empty is ignored and moves no pointer.
- Push accepted when (!full) or (full & pop in the same cycle). An accepted push writes mem[wptr[AW-1:0]] and increments wptr.
- Push while full with no pop: byte is dropped, wptr unchanged, overflow set to 1 on the next edge.
- Accepted pop increments rptr.
- Pointers wrap modulo 2*DEPTH naturally. There is no special-case wrap logic.
- Latency:
  - A byte pushed at edge N appears on out_data with out_valid=1 after edge N (visible in cycle N+1).
  - After a pop at edge N, the next entry is on out_data in cycle N+1.
- out_data = mem[rptr[AW-1:0]], read combinationally from the registered array. It carries no reset requirement.
- count = wptr - rptr (AW+1 bits, modular). full and empty are decoded from the pointers, not from count.
- Simultaneous push and pop:
  - Not full, not empty: both take effect, count unchanged.
  - Empty: only the push takes effect, because the pop is invalid.
  - Full: both take effect, count stays DEPTH, overflow is not set.
- clr=1 (rst=0): rptr=wptr=0 and overflow=0 on the next edge. A push or pop in the same cycle is discarded.
- overflow stays 1 until rst or clr, regardless of later pops.
- Reset or clr mid-burst: in-flight bytes are lost. The first push afterwards lands in entry 0.

Optional Feature:
- Macro: UART_RX_FIFO_OVF_CNT_EN.
- When defined:
  - Adds output ovf_cnt, 16 bits.
  - Increments by 1 for every dropped byte and saturates at 16'hFFFF.
  - Reset to 0 by rst or clr.
  - Increments on a drop in the same cycle that overflow first sets.
- When undefined: the port does not exist. No counter logic is generated, and the only overflow indication is the sticky flag.

Test Plan:
- Reset: hold rst 2 cycles -> count=0, empty=1, full=0, out_valid=0, overflow=0.
- Single byte: push 8'hA5 at edge N -> cycle N+1 shows out_valid=1, out_data=8'hA5, count=1. Pulse out_ready -> empty=1, count=0.
- Fill and drain: push 8'h00..8'h07 (DEPTH=8) -> full=1, count=8. Pop 8 -> bytes come out in order 00..07. Repeat 3 times to exercise pointer wrap -> order preserved.
- Overflow: fill to 8, then push 8'hFF with no pop -> byte dropped, count=8, overflow=1. Drain -> 00..07 with no FF. Optional counter -> ovf_cnt=1.
- Push and pop at full: full FIFO, push 8'h55 with out_ready=1 -> head popped, 55 accepted, count=8, overflow=0. 55 is the last byte drained.
- Flush mid-operation: count=5, assert clr with in_valid=1 -> next cycle count=0, overflow=0, empty=1. Next push 8'h3C -> out_data=8'h3C.
